// File: rtl/serial_transmitter.sv
// serial_transmitter: framed parallel-in serial-out transmitter (start, data, optional even parity, stop).
module serial_transmitter #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  input  logic             left,
  output logic             ready,
  output logic             serial,
  output logic             busy,
  output logic             done
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             left_q, left_d, par_q, par_d, serial_d, tick, last_bit;
  assign ready    = (state_q == IDLE);
  assign tick     = (div_q == DW'(DIV - 1));
  assign last_bit = (bit_q == BW'(WIDTH - 1));
  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    left_d  = left_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = START;
        sh_d    = data;
        left_d  = left;
        par_d   = ^data;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        if (last_bit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        else begin
          bit_d = bit_q + 1'b1;
          sh_d  = left_q ? sh_q << 1 : sh_q >> 1;
        end
      end
      PARITY: if (tick) state_d = STOP;
      default: if (tick) state_d = IDLE;
    endcase
    // serial is registered, so it is derived from the state being entered
    serial_d = (state_d == START) ? 1'b0 :
               (state_d == DATA) ? (left_d ? sh_d[WIDTH-1] : sh_d[0]) :
               (state_d == PARITY) ? par_d : 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      left_q  <= 1'b0;
      par_q   <= 1'b0;
      serial  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      left_q  <= left_d;
      par_q   <= par_d;
      serial  <= serial_d;
      busy    <= (state_d != IDLE);
      done    <= (state_q == STOP) && tick;
    end
  end
endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Parallel-in, serial-out framed transmitter. It is the sending end for the serial links that the library's SIPO shift register captures on the receive side.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Emits a frame on a single idle-high line: start bit (0), data bits, optional even-parity bit, stop bit (1).
- Each bit is held for DIV clocks. Sits between a producer (FIFO or register) and an off-block serial wire.

Parameters:
- WIDTH, 8, data bits per frame; WIDTH >= 2.
- DIV, 4, clock cycles per serial bit; DIV >= 1.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits, 0 omits it.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- data  input  WIDTH  word to send; sampled only on handshake.
- valid  input  1  producer has a word on data.
- left  input  1  bit order, sampled on handshake: 1 = MSB first, 0 = LSB first.
- ready  output  1  block can accept a word this cycle.
- serial  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (synchronous, active-high): takes effect at the next posedge, including mid-frame.
  - State goes to IDLE; bit and divider counters go to 0; the shift register clears.
  - serial=1, busy=0, done=0, ready=1 from the first cycle after reset.
  - A partial frame is abandoned with no done pulse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- ready = (state == IDLE), combinational from state.
- Handshake: accept occurs on a posedge where valid && ready.
  - data and left are captured into internal registers at that edge.
  - The FSM moves to START.
  - valid is ignored outside IDLE. data and left may change after acceptance without effect.
- Latency: serial drops to 0 in the first cycle after the accepting edge. serial, busy and done are registered outputs.
- Each state holds its bit for exactly DIV cycles, using a divider counter that runs 0..DIV-1 and then wraps to 0.
- START: serial=0 for DIV cycles, then DATA.
- DATA: WIDTH bits, each for DIV cycles.
  - left=0 sends data[0] first; left=1 sends data[WIDTH-1] first.
  - After the last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY: serial = XOR of all captured data bits (even parity) for DIV cycles, then STOP.
- STOP: serial=1 for DIV cycles, then IDLE.
- Frame length: (2 + WIDTH + PARITY_EN) * DIV cycles, counted from the first START cycle to the last STOP cycle inclusive.
- busy=1 in every cycle that state != IDLE.
- done=1 for exactly one cycle: the first IDLE cycle after STOP.
- Back-to-back frames:
  - If valid=1 in the done cycle, the word is accepted at that edge.
  - The next START begins the following cycle.
  - Exactly one idle-high cycle separates frames.
- DIV=1: every bit lasts one cycle; the divider is effectively constant 0 and no extra cycles are added.
- Simultaneous reset and valid: reset wins and the word is not accepted.
- Wrap-around: the bit counter runs 0..WIDTH-1 in DATA and is cleared on entry to DATA. It never exceeds WIDTH-1.

Test Plan:
- Reset, then idle with valid=0 for 20 cycles -> serial=1, ready=1, busy=0, done=0 throughout.
- WIDTH=8, DIV=4, PARITY_EN=1, data=8'h07, left=0 -> bit sequence 0,1,1,1,0,0,0,0,0,1,1.
  - Each bit lasts 4 cycles; total 44 cycles; busy high for 44 cycles.
  - done pulses in cycle 45 after acceptance.
- Same configuration, data=8'h07, left=1 -> bit sequence 0,0,0,0,0,0,1,1,1,1,1 (parity 1).
  - Change data to 8'hFF one cycle after acceptance -> frame unchanged.
- PARITY_EN=0, DIV=1, data=8'hA5, left=0, valid held high -> 10-cycle frames 0,1,0,1,0,0,1,0,1,1.
  - Consecutive frames separated by exactly one idle cycle; done once per frame.
- Assert reset at cycle 20 of a DIV=4 frame -> next cycle serial=1, busy=0, ready=1, no done.
  - A new word is accepted immediately afterwards and produces a full, correct frame.
- Loopback: serial feeds a ShiftRegisterSIPO (WIDTH=8) with left=1, enabled at the mid-bit cycle of each data bit.
  - After 8 data bits, the register Q equals the sent word 8'h3C.
